// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the sequential divider
package div_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam logic DIV0_FILL = 1'b1;
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: operand/request and result/status bundle of the divider
interface div_seq_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] RegAOut, RegBOut, DivHIOut, DivLOOut;
   logic SignedMode, DivCtrl, Busy, DivDone, Div0, Ovf;
   modport master (output RegAOut, RegBOut, SignedMode, DivCtrl,
                   input Busy, DivDone, Div0, Ovf, DivHIOut, DivLOOut);
   modport slave (input RegAOut, RegBOut, SignedMode, DivCtrl,
                  output Busy, DivDone, Div0, Ovf, DivHIOut, DivLOOut);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step on magnitudes
module div_step #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] den_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);
   logic [WIDTH:0]   sh;
   logic [WIDTH-1:0] diff;
   assign sh    = {rem_i, bit_i};
   assign q_o   = sh >= {1'b0, den_i};
   // a successful subtract always leaves a value below den_i, so WIDTH bits suffice
   assign diff  = sh[WIDTH-1:0] - den_i;
   assign rem_o = q_o ? diff : sh[WIDTH-1:0];
endmodule

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock, signed or unsigned
module div_seq import div_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input logic clock,
   input logic reset,
   div_seq_if.slave bus
);
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, den_q, den_d, araw_q, araw_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic sa_q, sa_d, sb_q, sb_d, sm_q, sm_d;
   logic busy_q, busy_d, done_q, done_d, div0_q, div0_d, ovf_q, ovf_d;
   logic sa_in, sb_in, step_q, last;
   logic [WIDTH-1:0] step_rem, qfin;

   assign sa_in = bus.SignedMode & bus.RegAOut[WIDTH-1];
   assign sb_in = bus.SignedMode & bus.RegBOut[WIDTH-1];
   assign last  = cnt_q == CNT_W'(1);
   assign qfin  = {quo_q[WIDTH-2:0], step_q};

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i(rem_q), .bit_i(quo_q[WIDTH-1]), .den_i(den_q),
      .rem_o(step_rem), .q_o(step_q)
   );

   // state register
   always_ff @(posedge clock or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;

   // next state; a zero divisor spends one RUN cycle, then goes straight to DONE
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: state_d = bus.DivCtrl ? RUN : IDLE;
         RUN:  state_d = !bus.DivCtrl ? IDLE : (den_q == '0 || last) ? DONE : RUN;
         DONE: state_d = bus.DivCtrl ? DONE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // datapath and registered outputs
   always_comb begin
      cnt_d = cnt_q; rem_d = rem_q; quo_d = quo_q; den_d = den_q; araw_d = araw_q;
      sa_d = sa_q; sb_d = sb_q; sm_d = sm_q;
      hi_d = hi_q; lo_d = lo_q;
      busy_d = busy_q; done_d = done_q; div0_d = div0_q; ovf_d = ovf_q;
      if (state_q == IDLE && bus.DivCtrl) begin
         sa_d = sa_in; sb_d = sb_in; sm_d = bus.SignedMode; araw_d = bus.RegAOut;
         quo_d = sa_in ? -bus.RegAOut : bus.RegAOut;
         den_d = sb_in ? -bus.RegBOut : bus.RegBOut;
         rem_d = '0; cnt_d = CNT_W'(WIDTH);
         busy_d = |bus.RegBOut; done_d = 1'b0; div0_d = 1'b0; ovf_d = 1'b0;
      end else if (state_q == RUN && !bus.DivCtrl) begin
         busy_d = 1'b0;
      end else if (state_q == RUN && den_q == '0) begin
         div0_d = 1'b1; done_d = 1'b1;
         lo_d = {WIDTH{DIV0_FILL}}; hi_d = araw_q;
      end else if (state_q == RUN) begin
         rem_d = step_rem; quo_d = qfin; cnt_d = cnt_q - CNT_W'(1);
         if (last) begin
            busy_d = 1'b0; done_d = 1'b1;
            lo_d = (sa_q ^ sb_q) ? -qfin : qfin;
            hi_d = sa_q ? -step_rem : step_rem;
            // a non-negative signed quotient with its MSB set only arises from MIN / -1
            ovf_d = sm_q & ~(sa_q ^ sb_q) & qfin[WIDTH-1];
         end
      end else if (state_q == DONE && !bus.DivCtrl) begin
         done_d = 1'b0;
      end
   end

   // datapath registers
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         cnt_q <= '0; rem_q <= '0; quo_q <= '0; den_q <= '0; araw_q <= '0;
         sa_q <= 1'b0; sb_q <= 1'b0; sm_q <= 1'b0;
         hi_q <= '0; lo_q <= '0;
         busy_q <= 1'b0; done_q <= 1'b0; div0_q <= 1'b0; ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d; rem_q <= rem_d; quo_q <= quo_d; den_q <= den_d; araw_q <= araw_d;
         sa_q <= sa_d; sb_q <= sb_d; sm_q <= sm_d;
         hi_q <= hi_d; lo_q <= lo_d;
         busy_q <= busy_d; done_q <= done_d; div0_q <= div0_d; ovf_q <= ovf_d;
      end

   assign bus.Busy     = busy_q;
   assign bus.DivDone  = done_q;
   assign bus.Div0     = div0_q;
   assign bus.Ovf      = ovf_q;
   assign bus.DivHIOut = hi_q;
   assign bus.DivLOOut = lo_q;
endmodule
